// File: rtl/pe_is_mctx_if.sv
// Bundles the load, MAC and result signals of one input-stationary PE.
// The master side drives loads and MAC operands; the slave side is the PE.
interface pe_is_mctx_if #(
  parameter int INPUT_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int PSUM_WIDTH   = 32,
  parameter int NUM_CTX      = 4
);
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  logic                            input_en;
  logic                            load_clr;
  logic signed [INPUT_WIDTH-1:0]   input_in;
  logic                            process_en;
  logic        [CTX_W-1:0]         ctx_sel;
  logic signed [WEIGHT_WIDTH-1:0]  weight_in;
  logic signed [PSUM_WIDTH-1:0]    psum_in;
  logic signed [INPUT_WIDTH-1:0]   input_out;
  logic                            input_out_vld;
  logic signed [WEIGHT_WIDTH-1:0]  weight_out;
  logic signed [PSUM_WIDTH-1:0]    psum_out;
  logic                            out_vld;
  logic                            sat_flag;
  logic        [NUM_CTX-1:0]       ctx_valid;
  logic                            ctx_full;

  modport master (
    output input_en, load_clr, input_in, process_en, ctx_sel, weight_in, psum_in,
    input  input_out, input_out_vld, weight_out, psum_out, out_vld, sat_flag,
           ctx_valid, ctx_full
  );

  modport slave (
    input  input_en, load_clr, input_in, process_en, ctx_sel, weight_in, psum_in,
    output input_out, input_out_vld, weight_out, psum_out, out_vld, sat_flag,
           ctx_valid, ctx_full
  );
endinterface

// File: rtl/pe_is_mctx.sv
// Multi-context input-stationary PE: saturating signed MAC over a selectable stored input.
// Define PE_MAC_PIPE_EN to insert a product register (MAC latency 2 instead of 1).
module pe_is_mctx #(
  parameter int INPUT_WIDTH  = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int PSUM_WIDTH   = 32,
  parameter int NUM_CTX      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pe_is_mctx_if.slave   bus
);
  localparam int CTX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int PROD_W = INPUT_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_W  = ((PSUM_WIDTH > PROD_W) ? PSUM_WIDTH : PROD_W) + 1;
  localparam logic [CTX_W-1:0] LAST_IDX  = CTX_W'(NUM_CTX - 1);
  localparam logic [CTX_W:0]   NUM_CTX_L = (CTX_W + 1)'(NUM_CTX);

  // Returns {saturated, clamped value}; the sum is wide enough to never overflow itself.
  function automatic logic [PSUM_WIDTH:0] sat_psum(input logic signed [SUM_W-1:0] s);
    logic signed [PSUM_WIDTH-1:0] lo;
    logic        [PSUM_WIDTH:0]   r;
    lo = s[PSUM_WIDTH-1:0];
    if (s == SUM_W'(lo))
      r = {1'b0, lo};
    else if (s[SUM_W-1])
      r = {1'b1, 1'b1, {(PSUM_WIDTH-1){1'b0}}};
    else
      r = {1'b1, 1'b0, {(PSUM_WIDTH-1){1'b1}}};
    return r;
  endfunction

  logic signed [INPUT_WIDTH-1:0]  ctx_q [NUM_CTX];
  logic        [CTX_W-1:0]        wr_ptr;
  logic        [CTX_W-1:0]        wr_idx;
  logic        [CTX_W-1:0]        wr_nxt;
  logic        [NUM_CTX-1:0]      ctx_vld_q;
  logic signed [INPUT_WIDTH-1:0]  in_fwd_q;
  logic                           in_fwd_vld_q;

  assign wr_idx = bus.load_clr ? '0 : wr_ptr;
  assign wr_nxt = (wr_idx == LAST_IDX) ? '0 : wr_idx + CTX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) ctx_q[i] <= '0;
      wr_ptr       <= '0;
      ctx_vld_q    <= '0;
      in_fwd_q     <= '0;
      in_fwd_vld_q <= 1'b0;
    end else begin
      in_fwd_vld_q <= bus.input_en;
      if (bus.input_en) begin
        ctx_q[wr_idx] <= bus.input_in;
        in_fwd_q      <= bus.input_in;
        wr_ptr        <= wr_nxt;
        ctx_vld_q     <= (bus.load_clr ? '0 : ctx_vld_q) | (NUM_CTX'(1) << wr_idx);
      end else if (bus.load_clr) begin
        wr_ptr    <= '0;
        ctx_vld_q <= '0;
      end
    end
  end

  // Stage p0: context read and product; out-of-range selects fall back to context 0.
  logic        [CTX_W-1:0]         rd_idx;
  logic signed [INPUT_WIDTH-1:0]   ctx_rd;
  logic signed [PROD_W-1:0]        prod_c;

  assign rd_idx = ({1'b0, bus.ctx_sel} < NUM_CTX_L) ? bus.ctx_sel : '0;
  assign ctx_rd = ctx_q[rd_idx];
  assign prod_c = ctx_rd * bus.weight_in;

  logic                            mac_vld;
  logic signed [PROD_W-1:0]        mac_prod;
  logic signed [WEIGHT_WIDTH-1:0]  mac_wght;

`ifdef PE_MAC_PIPE_EN
  logic signed [PROD_W-1:0]        prod_p0;
  logic signed [WEIGHT_WIDTH-1:0]  wght_p0;
  logic                            vld_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_p0 <= '0;
      wght_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= bus.process_en;
      if (bus.process_en) begin
        prod_p0 <= prod_c;
        wght_p0 <= bus.weight_in;
      end
    end
  end

  assign mac_vld  = vld_p0;
  assign mac_prod = prod_p0;
  assign mac_wght = wght_p0;
`else
  assign mac_vld  = bus.process_en;
  assign mac_prod = prod_c;
  assign mac_wght = bus.weight_in;
`endif

  // Stage p1: accumulate with psum_in and clamp.
  logic signed [SUM_W-1:0]         sum_c;
  logic        [PSUM_WIDTH:0]      sat_c;
  logic signed [PSUM_WIDTH-1:0]    psum_p1;
  logic signed [WEIGHT_WIDTH-1:0]  wght_p1;
  logic                            sat_p1;
  logic                            vld_p1;

  assign sum_c = SUM_W'(mac_prod) + SUM_W'(bus.psum_in);
  assign sat_c = sat_psum(sum_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_p1 <= '0;
      wght_p1 <= '0;
      sat_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= mac_vld;
      if (mac_vld) begin
        psum_p1 <= sat_c[PSUM_WIDTH-1:0];
        sat_p1  <= sat_c[PSUM_WIDTH];
        wght_p1 <= mac_wght;
      end
    end
  end

  assign bus.input_out     = in_fwd_q;
  assign bus.input_out_vld = in_fwd_vld_q;
  assign bus.weight_out    = wght_p1;
  assign bus.psum_out      = psum_p1;
  assign bus.out_vld       = vld_p1;
  assign bus.sat_flag      = sat_p1;
  assign bus.ctx_valid     = ctx_vld_q;
  assign bus.ctx_full      = &ctx_vld_q;
endmodule

// File: tb/tb_pe_is_mctx.sv
// Directed bench for pe_is_mctx: loads, MAC, saturation, wrap/clear, read-before-write, async reset.
module tb_pe_is_mctx;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pe_is_mctx_if #(.INPUT_WIDTH(16), .WEIGHT_WIDTH(16), .PSUM_WIDTH(32), .NUM_CTX(4)) bus ();

  pe_is_mctx #(.INPUT_WIDTH(16), .WEIGHT_WIDTH(16), .PSUM_WIDTH(32), .NUM_CTX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v);
    bus.input_en = 1'b1;
    bus.input_in = 16'(v);
    step();
    bus.input_en = 1'b0;
    check("load_out", bus.input_out, v);
    check("load_vld", bus.input_out_vld, 1);
  endtask

  task automatic do_mac(input logic [1:0] sel, input int w, input int p);
    bus.process_en = 1'b1;
    bus.ctx_sel    = sel;
    bus.weight_in  = 16'(w);
    bus.psum_in    = 32'(p);
    step();
    bus.process_en = 1'b0;
`ifdef PE_MAC_PIPE_EN
    check("pipe_gap_vld", bus.out_vld, 0);
    step();
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.input_en = 1'b0; bus.load_clr = 1'b0; bus.input_in = '0;
    bus.process_en = 1'b0; bus.ctx_sel = '0; bus.weight_in = '0; bus.psum_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    check("rst_psum", bus.psum_out, 0);
    check("rst_vld", bus.out_vld, 0);
    check("rst_wout", bus.weight_out, 0);
    check("rst_sat", bus.sat_flag, 0);
    check("rst_inout", bus.input_out, 0);
    check("rst_invld", bus.input_out_vld, 0);
    check("rst_ctxv", bus.ctx_valid, 0);
    check("rst_full", bus.ctx_full, 0);

    load(3); load(-2); load(7); load(100);
    check("ld_ctxv", bus.ctx_valid, 4'b1111);
    check("ld_full", bus.ctx_full, 1);
    step();
    check("idle_invld", bus.input_out_vld, 0);
    check("idle_inout", bus.input_out, 100);

    // -2*5 + 10 = 0
    do_mac(2'd1, 5, 10);
    check("mac_psum", bus.psum_out, 0);
    check("mac_wout", bus.weight_out, 5);
    check("mac_vld", bus.out_vld, 1);
    check("mac_sat", bus.sat_flag, 0);
    step();
    check("hold_vld", bus.out_vld, 0);
    check("hold_wout", bus.weight_out, 5);
    check("hold_psum", bus.psum_out, 0);

    // 100*-3 + 50 = -250
    do_mac(2'd3, -3, 50);
    check("mac2_psum", bus.psum_out, -250);
    check("mac2_wout", bus.weight_out, -3);

    // 5th load wraps onto context 0
    load(9);
    check("wrap_ctxv", bus.ctx_valid, 4'b1111);
    do_mac(2'd0, 1, 0);
    check("wrap_psum", bus.psum_out, 9);

    // wr_ptr now 1; load 6 there so the next write targets context 2 (holds 7)
    load(6);
    bus.input_en = 1'b1; bus.input_in = 16'sd8;
    bus.process_en = 1'b1; bus.ctx_sel = 2'd2; bus.weight_in = 16'sd1; bus.psum_in = 32'sd0;
    step();
    bus.input_en = 1'b0; bus.process_en = 1'b0;
`ifdef PE_MAC_PIPE_EN
    step();
`endif
    check("rbw_old", bus.psum_out, 7);
    do_mac(2'd2, 1, 0);
    check("rbw_new", bus.psum_out, 8);

    // clear + load together: writes context 0, only bit 0 valid
    bus.load_clr = 1'b1;
    load(11);
    bus.load_clr = 1'b0;
    check("clr_ctxv", bus.ctx_valid, 4'b0001);
    check("clr_full", bus.ctx_full, 0);
    do_mac(2'd0, 2, 1);
    check("clr_psum", bus.psum_out, 23);

    load(32'h7FFF);
    check("ptr1_ctxv", bus.ctx_valid, 4'b0011);

    do_mac(2'd1, 32'h7FFF, 32'h7FFFFFFF);
    check("satp_psum", bus.psum_out, 32'sh7FFFFFFF);
    check("satp_flag", bus.sat_flag, 1);
    do_mac(2'd1, -32768, 32'h80000000);
    check("satn_psum", bus.psum_out, 32'sh80000000);
    check("satn_flag", bus.sat_flag, 1);
    do_mac(2'd1, 1, 0);
    check("nosat_psum", bus.psum_out, 32767);
    check("nosat_flag", bus.sat_flag, 0);

    // load_clr alone keeps context data
    bus.load_clr = 1'b1;
    step();
    bus.load_clr = 1'b0;
    check("clr2_ctxv", bus.ctx_valid, 0);
    check("clr2_full", bus.ctx_full, 0);
    do_mac(2'd1, 1, 5);
    check("clr2_psum", bus.psum_out, 32772);

    // async reset between edges with a MAC in flight
    bus.process_en = 1'b1; bus.ctx_sel = 2'd1; bus.weight_in = 16'sd2; bus.psum_in = 32'sd0;
    step();
    bus.process_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst_psum", bus.psum_out, 0);
    check("arst_vld", bus.out_vld, 0);
    check("arst_wout", bus.weight_out, 0);
    check("arst_inout", bus.input_out, 0);
    check("arst_ctxv", bus.ctx_valid, 0);
    #1 rst_n = 1'b1;
    step();
    check("arst_stale1", bus.out_vld, 0);
    step();
    check("arst_stale2", bus.out_vld, 0);
    // contexts were cleared: 0*5 + 4
    do_mac(2'd2, 5, 4);
    check("arst_ctx0", bus.psum_out, 4);
    check("arst_macvld", bus.out_vld, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
